// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the ID-stage register file and its scoreboard.
package regfile_pkg;

    localparam int RF_DATA_W   = 64;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_ZERO_REG = 31;

    typedef logic [RF_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/dec_onehot_en.sv
// Enabled one-hot decoder: out = en ? onehot(in) : 0; indices past NUM_REGS give all-zero.
module dec_onehot_en #(
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                en,
    input  logic [ADDR_W-1:0]   in,
    output logic [NUM_REGS-1:0] out
);

    // Comparing against every legal index keeps out-of-range inputs at zero for free.
    always_comb begin
        out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            out[i] = en && (in == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// ID-stage register file: 1 write / 2 async read ports, optional write bypass, hardwired
// zero register and a per-register busy scoreboard for hazard detection.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = RF_ZERO_REG,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              busy_set_en,
    input  logic [ADDR_W-1:0] busy_set_addr,
    output logic              busy_a,
    output logic              busy_b
);

    logic [NUM_REGS-1:0] wr_sel_raw;
    logic [NUM_REGS-1:0] set_sel_raw;
    logic [NUM_REGS-1:0] nz_mask;
    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] set_sel;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    dec_onehot_en #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_wr_dec (
        .en  (wr_en),
        .in  (wr_addr),
        .out (wr_sel_raw)
    );

    dec_onehot_en #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_set_dec (
        .en  (busy_set_en),
        .in  (busy_set_addr),
        .out (set_sel_raw)
    );

    // The zero register is never written and never marked busy.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_nz
        assign nz_mask[i] = (i != ZERO_REG);
    end

    assign wr_sel  = wr_sel_raw & nz_mask;
    assign set_sel = set_sel_raw & nz_mask;

    // Set is applied after clear so a new producer issued in the retire cycle stays busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= wr_data;
                end
            end
            busy <= (busy & ~wr_sel) | set_sel;
        end
    end

    function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
        return (int'(idx) < NUM_REGS) && (int'(idx) != ZERO_REG);
    endfunction

    logic ok_a;
    logic ok_b;
    logic wr_hit_a;
    logic wr_hit_b;
    logic set_hit_a;
    logic set_hit_b;

    assign ok_a      = idx_ok(rd_addr_a);
    assign ok_b      = idx_ok(rd_addr_b);
    assign wr_hit_a  = wr_en && (wr_addr == rd_addr_a);
    assign wr_hit_b  = wr_en && (wr_addr == rd_addr_b);
    assign set_hit_a = busy_set_en && (busy_set_addr == rd_addr_a);
    assign set_hit_b = busy_set_en && (busy_set_addr == rd_addr_b);

    // Outputs are held at zero during reset so a pending write cannot leak through bypass.
    always_comb begin
        rd_data_a = '0;
        busy_a    = 1'b0;
        if (!reset && ok_a) begin
            rd_data_a = regs[rd_addr_a];
            busy_a    = busy[rd_addr_a];
            if (BYPASS && wr_hit_a) begin
                rd_data_a = wr_data;
                if (!set_hit_a) begin
                    busy_a = 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_data_b = '0;
        busy_b    = 1'b0;
        if (!reset && ok_b) begin
            rd_data_b = regs[rd_addr_b];
            busy_b    = busy[rd_addr_b];
            if (BYPASS && wr_hit_b) begin
                rd_data_b = wr_data;
                if (!set_hit_b) begin
                    busy_b = 1'b0;
                end
            end
        end
    end

endmodule
